// File: rtl/ordena_pkg.sv
// ordena_pkg: shared defaults, mode encodings and sorted-pair type for ordena_2_num.
package ordena_pkg;
    localparam int WIDTH_DEF    = 9;
    localparam int ORDER_ASC    = 0;
    localparam int ORDER_DESC   = 1;
    localparam int CMP_UNSIGNED = 0;
    localparam int CMP_SIGNED   = 1;
    // lo/hi name the first/second output slot (n1/n2), so hi <= lo in descending mode.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] lo;
        logic [WIDTH_DEF-1:0] hi;
        logic                 swapped;
        logic                 equal;
    } sorted_pair_t;
endpackage

// File: rtl/ordena_cmp_swap.sv
// ordena_cmp_swap: combinational compare-and-swap of two operands.
module ordena_cmp_swap
    import ordena_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DESCENDING = ORDER_ASC,
    parameter int SIGNED_CMP = CMP_UNSIGNED
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] first,
    output logic [WIDTH-1:0] second,
    output logic             swapped,
    output logic             equal
);
    logic w_a_lt_b;
    logic w_b_lt_a;
    always_comb begin
        w_a_lt_b = (SIGNED_CMP == CMP_SIGNED) ? ($signed(a) < $signed(b)) : (a < b);
        w_b_lt_a = (SIGNED_CMP == CMP_SIGNED) ? ($signed(b) < $signed(a)) : (b < a);
        // Strict compares keep equal operands in their original order.
        swapped  = (DESCENDING == ORDER_DESC) ? w_a_lt_b : w_b_lt_a;
        equal    = (a == b);
        first    = swapped ? b : a;
        second   = swapped ? a : b;
    end
endmodule

// File: rtl/ordena_2_num.sv
// ordena_2_num: registered two-operand sorter, latency 1, full throughput.
module ordena_2_num
    import ordena_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DESCENDING = ORDER_ASC,
    parameter int SIGNED_CMP = CMP_UNSIGNED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] n1_n,
    input  logic [WIDTH-1:0] n2_n,
    output logic [WIDTH-1:0] n1,
    output logic [WIDTH-1:0] n2,
    output logic             valid,
    output logic             swapped,
    output logic             equal
);
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_second;
    logic             w_swapped;
    logic             w_equal;
    logic [WIDTH-1:0] r_n1;
    logic [WIDTH-1:0] r_n2;
    logic             r_valid;
    logic             r_swapped;
    logic             r_equal;

    ordena_cmp_swap #(
        .WIDTH      (WIDTH),
        .DESCENDING (DESCENDING),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp_swap (
        .a       (n1_n),
        .b       (n2_n),
        .first   (w_first),
        .second  (w_second),
        .swapped (w_swapped),
        .equal   (w_equal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n1      <= '0;
            r_n2      <= '0;
            r_valid   <= 1'b0;
            r_swapped <= 1'b0;
            r_equal   <= 1'b0;
        end else if (ena) begin
            r_n1      <= w_first;
            r_n2      <= w_second;
            r_valid   <= 1'b1;
            r_swapped <= w_swapped;
            r_equal   <= w_equal;
        end
    end

    assign n1      = r_n1;
    assign n2      = r_n2;
    assign valid   = r_valid;
    assign swapped = r_swapped;
    assign equal   = r_equal;
endmodule

// File: tb/tb_ordena_2_num.sv
// tb_ordena_2_num: scoreboard bench over ascending/unsigned, signed and descending instances.
module tb_ordena_2_num;
    import ordena_pkg::*;

    typedef struct {
        sorted_pair_t p [3];
        logic         v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic [8:0] n1_n = '0;
    logic [8:0] n2_n = '0;
    logic [8:0] n1 [3];
    logic [8:0] n2 [3];
    logic       valid [3];
    logic       swapped [3];
    logic       equal [3];

    int errors = 0;
    int checks = 0;
    exp_t         sb [$];
    sorted_pair_t st [3];
    logic         st_v = 1'b0;

    always #5 clk = ~clk;

    ordena_2_num #(.WIDTH(9), .DESCENDING(0), .SIGNED_CMP(0)) dut_asc (
        .clk(clk), .rst(rst), .ena(ena), .n1_n(n1_n), .n2_n(n2_n),
        .n1(n1[0]), .n2(n2[0]), .valid(valid[0]), .swapped(swapped[0]), .equal(equal[0]));
    ordena_2_num #(.WIDTH(9), .DESCENDING(0), .SIGNED_CMP(1)) dut_sgn (
        .clk(clk), .rst(rst), .ena(ena), .n1_n(n1_n), .n2_n(n2_n),
        .n1(n1[1]), .n2(n2[1]), .valid(valid[1]), .swapped(swapped[1]), .equal(equal[1]));
    ordena_2_num #(.WIDTH(9), .DESCENDING(1), .SIGNED_CMP(0)) dut_dsc (
        .clk(clk), .rst(rst), .ena(ena), .n1_n(n1_n), .n2_n(n2_n),
        .n1(n1[2]), .n2(n2[2]), .valid(valid[2]), .swapped(swapped[2]), .equal(equal[2]));

    function automatic sorted_pair_t model(logic [8:0] a, logic [8:0] b, bit desc, bit sgn);
        sorted_pair_t r;
        int  va = sgn && a[8] ? int'(a) - 512 : int'(a);
        int  vb = sgn && b[8] ? int'(b) - 512 : int'(b);
        bit  take_b = desc ? (vb > va) : (vb < va);
        r.lo      = take_b ? b : a;
        r.hi      = take_b ? a : b;
        r.swapped = take_b;
        r.equal   = (a == b);
        return r;
    endfunction

    task automatic check(string tag, int m);
        exp_t e;
        logic [20:0] obs;
        logic [20:0] exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e   = sb[0];
        obs = {n1[m], n2[m], swapped[m], equal[m], valid[m]};
        exp = {e.p[m].lo, e.p[m].hi, e.p[m].swapped, e.p[m].equal, e.v};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s m%0d {n1,n2,sw,eq,v} got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                   tag, m, obs[20:12], obs[11:3], obs[2], obs[1], obs[0],
                   exp[20:12], exp[11:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(string tag, logic r, logic e, logic [8:0] a, logic [8:0] b);
        exp_t x;
        rst  = r;
        ena  = e;
        n1_n = a;
        n2_n = b;
        for (int m = 0; m < 3; m++) begin
            if (r) st[m] = '0;
            else if (e) st[m] = model(a, b, m == 2, m == 1);
        end
        st_v = r ? 1'b0 : (e ? 1'b1 : st_v);
        for (int m = 0; m < 3; m++) x.p[m] = st[m];
        x.v = st_v;
        sb.push_back(x);
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) check(tag, m);
        void'(sb.pop_front());
    endtask

    initial begin
        for (int m = 0; m < 3; m++) st[m] = '0;
        @(negedge clk);
        step("reset0", 1, 1, 9'd5, 9'd3);
        step("reset1", 1, 1, 9'd5, 9'd3);
        step("post_reset_idle", 0, 0, 9'd7, 9'd2);
        step("asc_swap", 0, 1, 9'd200, 9'd17);
        for (int i = 0; i < 100; i++) step("equal_hold", 0, 1, 9'd1, 9'd1);
        step("cap_3_9", 0, 1, 9'd3, 9'd9);
        step("hold0", 0, 0, 9'd511, 9'd0);
        step("hold1", 0, 0, 9'd511, 9'd0);
        step("hold2", 0, 0, 9'd511, 9'd0);
        step("cap_511_0", 0, 1, 9'd511, 9'd0);
        step("signed_1_1ff", 0, 1, 9'h001, 9'h1FF);
        step("pair_4_8", 0, 1, 9'd4, 9'd8);
        step("pair_8_4", 0, 1, 9'd8, 9'd4);
        step("zeros", 0, 1, 9'h000, 9'h000);
        step("ones", 0, 1, 9'h1FF, 9'h1FF);
        step("zero_ones", 0, 1, 9'h000, 9'h1FF);
        step("min_neg", 0, 1, 9'h100, 9'h001);
        step("neg_pair", 0, 1, 9'h1FE, 9'h180);
        step("mid_reset", 1, 1, 9'd100, 9'd50);
        step("after_reset", 0, 0, 9'd100, 9'd50);
        step("resume", 0, 1, 9'd100, 9'd50);
        for (int i = 0; i < 20; i++)
            step("random", 0, 1'($urandom_range(0, 1)), 9'($urandom), 9'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
